// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind uart_rx: SYNC, CMD, LEN, payload, CHK -> validated, buffered packet.
// Optional inter-byte timeout is compiled in with `define UART_PKT_TIMEOUT_EN.
module uart_rx_pkt_ctrl #(
   parameter logic [7:0] SYNC_BYTE     = 8'hA5,
   parameter int         MAX_LEN       = 16,
   parameter int         ADDR_W        = 4,
   parameter int         TIMEOUT_TICKS = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              baud_tick,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              pkt_valid,
   output logic [7:0]        pkt_cmd,
   output logic [7:0]        pkt_len,
   input  logic              pkt_ack,
   output logic              busy,
   output logic              err_chk,
   output logic              err_len,
   output logic              err_drop,
   output logic              err_timeout,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_HUNT = 3'd0,
      S_CMD  = 3'd1,
      S_LEN  = 3'd2,
      S_PAY  = 3'd3,
      S_CHK  = 3'd4
   } state_t;

   localparam logic [8:0] MAX_LEN_L = 9'(MAX_LEN);

   state_t     state, state_nx;
   logic [7:0] chk_acc, chk_acc_nx;
   logic [7:0] wr_idx, wr_idx_nx;
   logic [7:0] cmd_r, cmd_nx;
   logic [7:0] len_r, len_nx;
   logic       err_chk_nx, err_len_nx, err_drop_nx, err_timeout_nx;
   logic       valid_set;
   logic       wr_en;
   logic       byte_in;
   logic       tout_hit;
   logic [7:0] wr_idx_inc;

   logic [7:0] pay_mem [2**ADDR_W];

   // A pending ack releases the lock in the same cycle, so the byte is parsed, not dropped.
   assign byte_in    = rx_done && (!pkt_valid || pkt_ack);
   assign busy       = (state != S_HUNT);
   assign dbg_state  = state;
   assign wr_idx_inc = wr_idx + 8'd1;

`ifdef UART_PKT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   logic [TW-1:0] tick_cnt;

   assign tout_hit = busy && !rx_done && baud_tick && (tick_cnt == TW'(TIMEOUT_TICKS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tick_cnt <= '0;
      else if (!busy || rx_done || tout_hit)
         tick_cnt <= '0;
      else if (baud_tick)
         tick_cnt <= tick_cnt + TW'(1);
   end
`else
   assign tout_hit = 1'b0;
`endif

   always_comb begin
      state_nx       = state;
      chk_acc_nx     = chk_acc;
      wr_idx_nx      = wr_idx;
      cmd_nx         = cmd_r;
      len_nx         = len_r;
      err_chk_nx     = 1'b0;
      err_len_nx     = 1'b0;
      err_drop_nx    = rx_done && pkt_valid && !pkt_ack;
      err_timeout_nx = 1'b0;
      valid_set      = 1'b0;
      wr_en          = 1'b0;

      if (tout_hit) begin
         state_nx       = S_HUNT;
         err_timeout_nx = 1'b1;
      end else if (byte_in) begin
         case (state)
            S_HUNT: begin
               if (rx_data == SYNC_BYTE) begin
                  state_nx   = S_CMD;
                  chk_acc_nx = 8'h00;
                  wr_idx_nx  = 8'h00;
               end
            end
            S_CMD: begin
               cmd_nx     = rx_data;
               chk_acc_nx = chk_acc ^ rx_data;
               state_nx   = S_LEN;
            end
            S_LEN: begin
               len_nx     = rx_data;
               chk_acc_nx = chk_acc ^ rx_data;
               if ({1'b0, rx_data} > MAX_LEN_L) begin
                  err_len_nx = 1'b1;
                  state_nx   = S_HUNT;
               end else if (rx_data == 8'h00) begin
                  state_nx = S_CHK;
               end else begin
                  state_nx = S_PAY;
               end
            end
            S_PAY: begin
               wr_en      = 1'b1;
               chk_acc_nx = chk_acc ^ rx_data;
               wr_idx_nx  = wr_idx_inc;
               if (wr_idx_inc == len_r)
                  state_nx = S_CHK;
            end
            S_CHK: begin
               state_nx = S_HUNT;
               if (rx_data == chk_acc)
                  valid_set = 1'b1;
               else
                  err_chk_nx = 1'b1;
            end
            default: state_nx = S_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_HUNT;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_acc     <= 8'h00;
         wr_idx      <= 8'h00;
         cmd_r       <= 8'h00;
         len_r       <= 8'h00;
         err_chk     <= 1'b0;
         err_len     <= 1'b0;
         err_drop    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         chk_acc     <= chk_acc_nx;
         wr_idx      <= wr_idx_nx;
         cmd_r       <= cmd_nx;
         len_r       <= len_nx;
         err_chk     <= err_chk_nx;
         err_len     <= err_len_nx;
         err_drop    <= err_drop_nx;
         err_timeout <= err_timeout_nx;
      end
   end

   // Held packet descriptor; only a validated CHK byte updates it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_valid <= 1'b0;
         pkt_cmd   <= 8'h00;
         pkt_len   <= 8'h00;
      end else if (valid_set) begin
         pkt_valid <= 1'b1;
         pkt_cmd   <= cmd_r;
         pkt_len   <= len_r;
      end else if (pkt_ack) begin
         pkt_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         pay_mem[wr_idx[ADDR_W-1:0]] <= rx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_data <= 8'h00;
      else
         rd_data <= pay_mem[rd_addr];
   end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl: scoreboard of expected packet/error events,
// direct checks on reset, buffer reads, lock/ack behaviour and the timeout option.
module tb_uart_rx_pkt_ctrl;
  localparam int ADDR_W = 4;
  localparam int MAX_LEN = 16;

  logic clk = 1'b0;
  logic rst;
  logic baud_tick;
  logic [7:0] rx_data;
  logic rx_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0] rd_data;
  logic pkt_valid;
  logic [7:0] pkt_cmd;
  logic [7:0] pkt_len;
  logic pkt_ack;
  logic busy;
  logic err_chk;
  logic err_len;
  logic err_drop;
  logic err_timeout;
  logic [2:0] dbg_state;

  // event encoding: [19:16] kind (1 pkt, 2 chk, 3 len, 4 drop, 5 timeout), [15:8] cmd, [7:0] len
  logic [19:0] exp_q[$];
  logic [7:0] pay_buf [MAX_LEN];
  int n_vec = 0;
  int n_err = 0;

  uart_rx_pkt_ctrl dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_data(rx_data), .rx_done(rx_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .pkt_valid(pkt_valid), .pkt_cmd(pkt_cmd),
    .pkt_len(pkt_len), .pkt_ack(pkt_ack), .busy(busy), .err_chk(err_chk), .err_len(err_len),
    .err_drop(err_drop), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic observe(input logic [19:0] ev);
    if (exp_q.size() == 0) check("sb_unexpected", 32'(ev), 32'h0);
    else check("sb_event", 32'(ev), 32'(exp_q.pop_front()));
  endtask

  // monitor
  logic prev_valid = 1'b0;
  logic [3:0] prev_err = 4'h0;
  always @(negedge clk) begin
    logic [3:0] errs;
    errs = {err_timeout, err_drop, err_len, err_chk};
    if (!rst) begin
      if (pkt_valid && !prev_valid) observe({4'd1, pkt_cmd, pkt_len});
      for (int i = 0; i < 4; i++) begin
        if (errs[i]) begin
          observe({4'(i + 2), 16'h0});
          check("err_width", 32'(prev_err[i]), 32'h0);
        end
      end
      if (errs != 4'h0) check("err_excl", 32'($countones(errs)), 32'd1);
    end
    prev_valid = pkt_valid;
    prev_err = errs;
  end

  // drivers
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sb_drain(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) pay_buf[i] = 8'($urandom_range(0, 255));
  endtask

  // chk_mask != 0 corrupts the checksum byte
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] chk_mask);
    logic [7:0] chk;
    chk = cmd ^ len;
    for (int i = 0; i < int'(len); i++) chk ^= pay_buf[i];
    if (chk_mask == 8'h00) exp_q.push_back({4'd1, cmd, len});
    else exp_q.push_back({4'd2, 16'h0});
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(len);
    for (int i = 0; i < int'(len); i++) send_byte(pay_buf[i]);
    send_byte(chk ^ chk_mask);
    sb_drain("frame");
  endtask

  task automatic read_payload(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rd_addr = ADDR_W'(i);
      @(negedge clk);
      check("rd_data", 32'(rd_data), 32'(pay_buf[i]));
    end
  endtask

  task automatic do_ack;
    @(negedge clk);
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
    check("ack_clear", 32'(pkt_valid), 32'h0);
  endtask

  task automatic tick;
    @(negedge clk);
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    baud_tick = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    rd_addr = '0;
    pkt_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(pkt_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cmd", 32'(pkt_cmd), 32'h0);
    check("rst_len", 32'(pkt_len), 32'h0);
    check("rst_rd", 32'(rd_data), 32'h0);
    check("rst_errs", 32'({err_chk, err_len, err_drop, err_timeout}), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    rst = 1'b0;

    // good 3-byte packet
    pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h33;
    send_byte(8'h5C);
    check("hunt_ignore", 32'(busy), 32'h0);
    run_frame(8'h10, 8'h03, 8'h00);
    check("t1_valid", 32'(pkt_valid), 32'h1);
    check("t1_cmd", 32'(pkt_cmd), 32'h10);
    check("t1_len", 32'(pkt_len), 32'h03);
    check("t1_busy", 32'(busy), 32'h0);
    read_payload(3);
    do_ack;

    // bad checksum (sent 00, correct 33), then a good frame
    pay_buf[0] = 8'hAA; pay_buf[1] = 8'hBB;
    run_frame(8'h20, 8'h02, 8'h33);
    check("t2_valid", 32'(pkt_valid), 32'h0);
    check("t2_busy", 32'(busy), 32'h0);
    fill_random(5);
    run_frame(8'h21, 8'h05, 8'h00);
    read_payload(5);
    do_ack;

    // oversize LEN, trailing bytes ignored in HUNT
    exp_q.push_back({4'd3, 16'h0});
    send_byte(8'hA5);
    check("t3_busy_sync", 32'(busy), 32'h1);
    send_byte(8'h01);
    send_byte(8'h11);
    check("t3_busy_abort", 32'(busy), 32'h0);
    for (int i = 0; i < 17; i++) begin
      send_byte(8'($urandom_range(0, 8'hA4)));
      check("t3_hunt", 32'(busy), 32'h0);
    end
    sb_drain("t3");

    // LEN at the MAX_LEN boundary
    fill_random(MAX_LEN);
    run_frame(8'h7E, 8'(MAX_LEN), 8'h00);
    check("max_len", 32'(pkt_len), 32'(MAX_LEN));
    read_payload(MAX_LEN);
    do_ack;

    // zero-length packet
    run_frame(8'h30, 8'h00, 8'h00);
    check("t5_valid", 32'(pkt_valid), 32'h1);
    check("t5_len", 32'(pkt_len), 32'h0);

    // lock: byte dropped, fields stable
    exp_q.push_back({4'd4, 16'h0});
    send_byte(8'hA5);
    check("t4_cmd", 32'(pkt_cmd), 32'h30);
    check("t4_len", 32'(pkt_len), 32'h0);
    check("t4_valid", 32'(pkt_valid), 32'h1);
    check("t4_busy", 32'(busy), 32'h0);
    sb_drain("t4_drop");
    // ack and SYNC together: byte accepted
    @(negedge clk);
    pkt_ack = 1'b1;
    rx_data = 8'hA5;
    rx_done = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
    rx_done = 1'b0;
    check("t4_ack_valid", 32'(pkt_valid), 32'h0);
    check("t4_ack_busy", 32'(busy), 32'h1);
    exp_q.push_back({4'd1, 8'h50, 8'h00});
    send_byte(8'h50);
    send_byte(8'h00);
    send_byte(8'h50);
    sb_drain("t4_frame");
    do_ack;

    // reset mid-packet
    send_byte(8'hA5);
    send_byte(8'h10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    fill_random(2);
    run_frame(8'h12, 8'h02, 8'h00);
    read_payload(2);
    do_ack;

    // random frames
    for (int f = 0; f < 6; f++) begin
      logic [7:0] len;
      logic bad;
      len = 8'($urandom_range(0, MAX_LEN));
      bad = ($urandom_range(0, 2) == 0);
      fill_random(int'(len));
      run_frame(8'($urandom_range(0, 255)), len, bad ? 8'($urandom_range(1, 255)) : 8'h00);
      check("rnd_valid", 32'(pkt_valid), bad ? 32'h0 : 32'h1);
      if (!bad) begin
        read_payload(int'(len));
        do_ack;
      end
    end

    // inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h40);
    for (int i = 0; i < 39; i++) tick;
    check("t6_busy_39", 32'(busy), 32'h1);
`ifdef UART_PKT_TIMEOUT_EN
    exp_q.push_back({4'd5, 16'h0});
    tick;
    @(negedge clk);
    check("t6_busy_after", 32'(busy), 32'h0);
    sb_drain("t6");
`else
    tick;
    @(negedge clk);
    check("t6_busy_after", 32'(busy), 32'h1);
    exp_q.push_back({4'd1, 8'h40, 8'h00});
    send_byte(8'h00);
    send_byte(8'h40);
    sb_drain("t6");
    do_ack;
`endif

    check("final_drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
